// File: rtl/pong_pkg.sv
// Shared match-state definitions, BCD score type and helpers.
// Used by match_ctrl, bcd_score_counter, the color mapper and the game FSM.
package pong_pkg;

  // State encodings exported to consumers of the 3-bit state bus.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_RALLY     = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_POINT     = 3'd4;
  localparam logic [2:0] ST_GAME_OVER = 3'd5;

  localparam int unsigned BCD_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_SERVE     = ST_SERVE,
    S_RALLY     = ST_RALLY,
    S_PAUSED    = ST_PAUSED,
    S_POINT     = ST_POINT,
    S_GAME_OVER = ST_GAME_OVER
  } match_state_t;

  // Two BCD digits: tens in [7:4], ones in [3:0].
  typedef logic [BCD_W-1:0] bcd_score_t;

  // Binary (0..99) to two-digit BCD, for elaboration-time constants.
  function automatic bcd_score_t to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Two-digit BCD to binary 0..99.
  function automatic logic [6:0] bcd_to_bin(input bcd_score_t s);
    return 7'({3'd0, s[7:4]} * 7'd10 + {3'd0, s[3:0]});
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Saturating two-digit BCD score counter (0..99), one per player.
// Ports:
//   Clk      - system clock, rising edge
//   Reset_n  - synchronous active-low reset
//   i_clear  - clear score to 00 (has priority over i_inc)
//   i_inc    - add one point; holds at 99
//   o_score  - registered BCD score
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       i_clear,
  input  logic       i_inc,
  output bcd_score_t o_score
);

  bcd_score_t r_score;

  // Ones digit wraps 9->0 carrying into tens; 99 is sticky.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_score <= '0;
    end else if (i_clear) begin
      r_score <= '0;
    end else if (i_inc && (r_score != 8'h99)) begin
      if (r_score[3:0] == 4'd9) begin
        r_score <= {r_score[7:4] + 4'd1, 4'd0};
      end else begin
        r_score <= {r_score[7:4], r_score[3:0] + 4'd1};
      end
    end
  end

  assign o_score = r_score;

endmodule

// File: rtl/match_ctrl.sv
// Pong match controller: serve timing, rally, pause, scoring and win detection.
// Optional macro PONG_WIN_BY_TWO_EN: win needs >= WIN_SCORE and a lead of at
// least two over every other player (99 always wins). Undefined: exact
// WIN_SCORE wins.
// Ports:
//   Clk, Reset_n   - clock and synchronous active-low reset
//   frame_tick     - one pulse per video frame (serve timer)
//   start          - begins a match from IDLE or GAME_OVER
//   pause          - toggles pause from SERVE/RALLY
//   point_valid    - a point was scored by point_player (RALLY only)
//   state          - current match state (pong_pkg ST_* encoding)
//   scores         - BCD score per player, player 0 in [7:0]
//   serve_player   - player currently serving
//   ball_en        - high only in RALLY
//   winner         - winning player, qualified by winner_valid
//   winner_valid   - high only in GAME_OVER
module match_ctrl
  import pong_pkg::*;
#(
  parameter  int unsigned NUM_PLAYERS  = 2,
  parameter  int unsigned WIN_SCORE    = 11,
  parameter  int unsigned SERVE_FRAMES = 60,
  localparam int unsigned PW           = $clog2(NUM_PLAYERS)
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     frame_tick,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     point_valid,
  input  logic [PW-1:0]            point_player,
  output logic [2:0]               state,
  output logic [8*NUM_PLAYERS-1:0] scores,
  output logic [PW-1:0]            serve_player,
  output logic                     ball_en,
  output logic [PW-1:0]            winner,
  output logic                     winner_valid
);

  localparam int unsigned PWX  = PW + 1;
  localparam int unsigned CNT_W = 8;

  match_state_t     r_state;
  match_state_t     r_resume;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_serve;
  logic [PW-1:0]    r_scorer;
  logic [PW-1:0]    r_winner;
  logic             r_ball_en;
  logic             r_winner_valid;

  bcd_score_t       w_score [NUM_PLAYERS];
  logic             w_point_ok;
  logic             w_accept_point;
  logic             w_clear;
  bcd_score_t       w_scorer_score;
  logic             w_win;

  // Out-of-range scorer indices (possible when NUM_PLAYERS is not a power of 2) are dropped.
  assign w_point_ok     = point_valid && ({1'b0, point_player} < PWX'(NUM_PLAYERS));
  assign w_accept_point = (r_state == S_RALLY) && w_point_ok;
  assign w_clear        = start && ((r_state == S_IDLE) || (r_state == S_GAME_OVER));

  // Per-player score counters; increment lands on the RALLY->POINT edge.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic w_inc;
    assign w_inc = w_accept_point && (point_player == PW'(g));

    bcd_score_counter u_score (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .i_clear (w_clear),
      .i_inc   (w_inc),
      .o_score (w_score[g])
    );

    assign scores[8*g +: 8] = w_score[g];
  end

  // Evaluated in POINT, where scores already include the latest point.
  assign w_scorer_score = w_score[r_scorer];

`ifdef PONG_WIN_BY_TWO_EN
  always_comb begin
    logic w_lead_ok;
    w_lead_ok = 1'b1;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if ((PW'(i) != r_scorer) &&
          ((bcd_to_bin(w_score[i]) + 7'd2) > bcd_to_bin(w_scorer_score))) begin
        w_lead_ok = 1'b0;
      end
    end
    w_win = (w_scorer_score == 8'h99) ||
            ((bcd_to_bin(w_scorer_score) >= 7'(WIN_SCORE)) && w_lead_ok);
  end
`else
  assign w_win = (w_scorer_score == to_bcd(WIN_SCORE));
`endif

  // Match FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state        <= S_IDLE;
      r_resume       <= S_SERVE;
      r_cnt          <= '0;
      r_serve        <= '0;
      r_scorer       <= '0;
      r_winner       <= '0;
      r_ball_en      <= 1'b0;
      r_winner_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SERVE;
            r_cnt   <= '0;
            r_serve <= '0;
          end
        end

        S_SERVE: begin
          if (pause) begin
            r_resume <= S_SERVE;
            r_state  <= S_PAUSED;
          end else if (frame_tick) begin
            if (r_cnt == CNT_W'(SERVE_FRAMES - 1)) begin
              r_state   <= S_RALLY;
              r_ball_en <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        // A point beats a same-cycle pause.
        S_RALLY: begin
          if (w_point_ok) begin
            r_scorer  <= point_player;
            r_state   <= S_POINT;
            r_ball_en <= 1'b0;
          end else if (pause) begin
            r_resume  <= S_RALLY;
            r_state   <= S_PAUSED;
            r_ball_en <= 1'b0;
          end
        end

        S_PAUSED: begin
          if (pause) begin
            r_state   <= r_resume;
            r_ball_en <= (r_resume == S_RALLY);
          end
        end

        S_POINT: begin
          if (w_win) begin
            r_state        <= S_GAME_OVER;
            r_winner       <= r_scorer;
            r_winner_valid <= 1'b1;
          end else begin
            r_state <= S_SERVE;
            r_cnt   <= '0;
            r_serve <= (r_serve == PW'(NUM_PLAYERS - 1)) ? '0 : r_serve + PW'(1);
          end
        end

        S_GAME_OVER: begin
          if (start) begin
            r_state        <= S_SERVE;
            r_cnt          <= '0;
            r_serve        <= '0;
            r_winner_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign state        = r_state;
  assign serve_player = r_serve;
  assign ball_en      = r_ball_en;
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed self-checking bench for match_ctrl (2 players, win at 11, 3-frame serve).
// Expectations follow PONG_WIN_BY_TWO_EN when defined.
module tb_match_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        point_valid = 1'b0;
  logic [0:0]  point_player = 1'b0;
  logic [2:0]  state;
  logic [15:0] scores;
  logic [0:0]  serve_player;
  logic        ball_en;
  logic [0:0]  winner;
  logic        winner_valid;

  int n_cmp = 0;
  int n_bad = 0;

  match_ctrl #(
    .NUM_PLAYERS  (2),
    .WIN_SCORE    (11),
    .SERVE_FRAMES (3)
  ) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .start        (start),
    .pause        (pause),
    .point_valid  (point_valid),
    .point_player (point_player),
    .state        (state),
    .scores       (scores),
    .serve_player (serve_player),
    .ball_en      (ball_en),
    .winner       (winner),
    .winner_valid (winner_valid)
  );

  always #5 Clk = ~Clk;

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Tick frames until RALLY, bounded.
  task automatic to_rally();
    for (int k = 0; k < 8 && state !== 3'd2; k++) tick();
    if (state !== 3'd2) begin
      n_cmp++; n_bad++;
      $display("FAIL to_rally_timeout: state=%0d required=2", state);
    end
  endtask

  // Serve, score one point for p, and leave POINT.
  task automatic score_point(input logic [0:0] p);
    to_rally();
    point_valid  = 1'b1;
    point_player = p;
    step();
    point_valid  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    step();
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (scores !== 16'h0000) begin n_bad++; $display("FAIL reset_scores: got %h want 0000", scores); end
    n_cmp++; if ({ball_en, winner_valid, winner, serve_player} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {ball_en, winner_valid, winner, serve_player});
    end
  endtask

  task automatic test_serve();
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL start_to_serve: got %0d want 1", state); end
    tick(); tick();
    n_cmp++; if (state !== 3'd1 || ball_en !== 1'b0) begin
      n_bad++; $display("FAIL serve_two_ticks: state=%0d ball_en=%b want 1/0", state, ball_en);
    end
    tick();
    n_cmp++; if (state !== 3'd2 || ball_en !== 1'b1) begin
      n_bad++; $display("FAIL serve_third_tick: state=%0d ball_en=%b want 2/1", state, ball_en);
    end
  endtask

  // Player 1 scores ten: BCD wrap to 10 and serve rotation.
  task automatic test_bcd_rotation();
    logic [0:0] exp_sp;
    for (int i = 0; i < 10; i++) begin
      score_point(1'b1);
      exp_sp = 1'((i + 1) % 2);
      n_cmp++; if (serve_player !== exp_sp || state !== 3'd1) begin
        n_bad++; $display("FAIL rotation_%0d: sp=%0d state=%0d want %0d/1", i, serve_player, state, exp_sp);
      end
    end
    n_cmp++; if (scores !== 16'h1000) begin n_bad++; $display("FAIL bcd_wrap: got %h want 1000", scores); end
  endtask

  task automatic test_win();
    for (int i = 0; i < 10; i++) score_point(1'b0);
    n_cmp++; if (scores !== 16'h1010 || state !== 3'd1) begin
      n_bad++; $display("FAIL ten_all: scores=%h state=%0d want 1010/1", scores, state);
    end
    score_point(1'b0);
`ifdef PONG_WIN_BY_TWO_EN
    n_cmp++; if (scores !== 16'h1011 || state !== 3'd1) begin
      n_bad++; $display("FAIL lead_one_no_win: scores=%h state=%0d want 1011/1", scores, state);
    end
    score_point(1'b0);
    n_cmp++; if (scores !== 16'h1012) begin n_bad++; $display("FAIL win_scores: got %h want 1012", scores); end
`else
    n_cmp++; if (scores !== 16'h1011) begin n_bad++; $display("FAIL win_scores: got %h want 1011", scores); end
`endif
    n_cmp++; if (state !== 3'd5 || winner_valid !== 1'b1 || winner !== 1'b0 || ball_en !== 1'b0) begin
      n_bad++; $display("FAIL game_over: state=%0d wv=%b winner=%0d ball_en=%b want 5/1/0/0",
                        state, winner_valid, winner, ball_en);
    end
    point_valid = 1'b1; point_player = 1'b1; step(); point_valid = 1'b0; step();
`ifdef PONG_WIN_BY_TWO_EN
    n_cmp++; if (scores !== 16'h1012 || state !== 3'd5) begin
      n_bad++; $display("FAIL game_over_hold: scores=%h state=%0d want 1012/5", scores, state);
    end
`else
    n_cmp++; if (scores !== 16'h1011 || state !== 3'd5) begin
      n_bad++; $display("FAIL game_over_hold: scores=%h state=%0d want 1011/5", scores, state);
    end
`endif
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (state !== 3'd1 || scores !== 16'h0000 || serve_player !== 1'b0 || winner_valid !== 1'b0) begin
      n_bad++; $display("FAIL restart: state=%0d scores=%h sp=%0d wv=%b want 1/0000/0/0",
                        state, scores, serve_player, winner_valid);
    end
  endtask

  task automatic test_pause();
    tick();
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++; if (state !== 3'd3 || ball_en !== 1'b0) begin
      n_bad++; $display("FAIL pause_serve: state=%0d ball_en=%b want 3/0", state, ball_en);
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL paused_hold: got %0d want 3", state); end
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL unpause_serve: got %0d want 1", state); end
    tick();
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL frozen_cnt_early: got %0d want 1", state); end
    tick();
    n_cmp++; if (state !== 3'd2 || ball_en !== 1'b1) begin
      n_bad++; $display("FAIL frozen_cnt_release: state=%0d ball_en=%b want 2/1", state, ball_en);
    end
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++; if (state !== 3'd3 || ball_en !== 1'b0) begin
      n_bad++; $display("FAIL pause_rally: state=%0d ball_en=%b want 3/0", state, ball_en);
    end
    pause = 1'b1; step(); pause = 1'b0;
    n_cmp++; if (state !== 3'd2 || ball_en !== 1'b1) begin
      n_bad++; $display("FAIL unpause_rally: state=%0d ball_en=%b want 2/1", state, ball_en);
    end
    pause = 1'b1; point_valid = 1'b1; point_player = 1'b0;
    step();
    pause = 1'b0; point_valid = 1'b0;
    n_cmp++; if (state !== 3'd4 || scores !== 16'h0001) begin
      n_bad++; $display("FAIL point_beats_pause: state=%0d scores=%h want 4/0001", state, scores);
    end
    step();
    n_cmp++; if (state !== 3'd1 || serve_player !== 1'b1) begin
      n_bad++; $display("FAIL after_point: state=%0d sp=%0d want 1/1", state, serve_player);
    end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; step(); start = 1'b0;
    n_cmp++; if (state !== 3'd1 || scores !== 16'h0001 || serve_player !== 1'b1) begin
      n_bad++; $display("FAIL start_in_serve: state=%0d scores=%h sp=%0d want 1/0001/1", state, scores, serve_player);
    end
  endtask

  task automatic test_reset_mid_rally();
    for (int i = 0; i < 4; i++) score_point(1'b0);
    for (int i = 0; i < 3; i++) score_point(1'b1);
    to_rally();
    n_cmp++; if (scores !== 16'h0305 || state !== 3'd2) begin
      n_bad++; $display("FAIL pre_reset: scores=%h state=%0d want 0305/2", scores, state);
    end
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    n_cmp++; if (state !== 3'd0 || scores !== 16'h0000) begin
      n_bad++; $display("FAIL mid_rally_reset: state=%0d scores=%h want 0/0000", state, scores);
    end
    n_cmp++; if ({ball_en, winner_valid, winner, serve_player} !== 4'b0000) begin
      n_bad++; $display("FAIL mid_rally_reset_flags: got %b want 0000", {ball_en, winner_valid, winner, serve_player});
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bcd_rotation();
    test_win();
    test_pause();
    test_start_ignored();
    test_reset_mid_rally();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
